// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 decoder for varuint32/varint32/varuint64/varint64 immediates.
// Optional macro LEB128_STRICT_EN rejects unused payload bits in the last byte of a maximum-length encoding.
module leb128_decoder #(
  parameter int MAX_BYTES32 = 5,
  parameter int MAX_BYTES64 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        is_64,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [63:0] value,
  output logic [3:0]  length,
  output logic        value_valid,
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, DECODE, DONE, ERROR} state_t;

  state_t      state, next_state;
  logic [63:0] acc, acc_next, ext_value, final_value;
  logic [6:0]  shift, shift_next;
  logic [3:0]  length_next, max_len;
  logic        sgn_q, w64_q, err_q;
  logic        accept, overflow, strict_bad;

  assign accept = (state == DECODE) && byte_valid;

  // Payload bits beyond bit 63 fall off the 64-bit shift; sign fill covers [width-1:s].
  always_comb begin
    acc_next    = acc | ({57'd0, byte_in[6:0]} << shift);
    shift_next  = shift + 7'd7;
    length_next = length + 4'd1;
    max_len     = w64_q ? 4'(MAX_BYTES64) : 4'(MAX_BYTES32);
    overflow    = byte_in[7] && (length_next == max_len);
    ext_value   = acc_next;
    if (sgn_q && byte_in[6] && (shift_next < (w64_q ? 7'd64 : 7'd32)))
      ext_value = acc_next | (~64'd0 << shift_next);
    if (w64_q)
      final_value = ext_value;
    else if (sgn_q)
      final_value = {{32{ext_value[31]}}, ext_value[31:0]};
    else
      final_value = {32'd0, ext_value[31:0]};
  end

`ifdef LEB128_STRICT_EN
  always_comb begin
    strict_bad = 1'b0;
    if (!byte_in[7] && (length_next == max_len)) begin
      case ({w64_q, sgn_q})
        2'b00:   strict_bad = (byte_in[6:4] != 3'd0);
        2'b01:   strict_bad = (byte_in[6:3] != 4'h0) && (byte_in[6:3] != 4'hF);
        2'b10:   strict_bad = (byte_in[6:1] != 6'd0);
        default: strict_bad = (byte_in[6:0] != 7'h00) && (byte_in[6:0] != 7'h7F);
      endcase
    end
  end
`else
  assign strict_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = DECODE;
      DECODE: begin
        if (accept) begin
          if (!byte_in[7])
            next_state = strict_bad ? ERROR : DONE;
          else if (overflow)
            next_state = ERROR;
        end
      end
      DONE:    next_state = IDLE;
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_ready  = (state == DECODE);
    busy        = (state != IDLE);
    value_valid = (state == DONE);
    error       = err_q;
  end

  // Datapath: decode context is latched on start; value is written only when a decode ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc    <= 64'd0;
      shift  <= 7'd0;
      length <= 4'd0;
      value  <= 64'd0;
      sgn_q  <= 1'b0;
      w64_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgn_q  <= is_signed;
            w64_q  <= is_64;
            acc    <= 64'd0;
            shift  <= 7'd0;
            length <= 4'd0;
            err_q  <= 1'b0;
          end
        end
        DECODE: begin
          if (accept) begin
            acc    <= acc_next;
            shift  <= shift_next;
            length <= length_next;
            if (next_state == DONE) begin
              value <= final_value;
            end else if (next_state == ERROR) begin
              value <= 64'd0;
              err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
